// File: rtl/serial_add_sub.sv
// Multi-cycle add/subtract unit: processes the operands LSB-first, DIGIT bits per clock,
// behind a start/busy/done handshake, and registers sum, carry, overflow and zero.
module serial_add_sub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_add_sub: WIDTH must be >= 2 and an integer multiple of DIGIT");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sh, a_sh_next;
    logic [WIDTH-1:0] b_sh, b_sh_next;
    logic [WIDTH-1:0] res, res_next;
    logic             c, c_next_reg;
    logic [CW-1:0]    cnt, cnt_next;
    logic             busy_next, done_next;
    logic [WIDTH-1:0] sum_next;
    logic             carry_next, overflow_next, zero_next;

    logic [DIGIT-1:0] d;
    logic             c_next;
    logic             c_msb_in;
    logic [WIDTH-1:0] d_ext;
    logic [WIDTH-1:0] res_shift;
    logic             last;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves one
        // unassigned; otherwise synthesis infers a latch to hold the old value.
        {c_next, d} = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, c};
        // Sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out of the digit's top bit.
        c_msb_in    = d[DIGIT-1] ^ a_sh[DIGIT-1] ^ b_sh[DIGIT-1];
        d_ext       = '0;
        d_ext[DIGIT-1:0] = d;
        res_shift   = (res >> DIGIT) | (d_ext << (WIDTH - DIGIT));
        last        = (cnt == CW'(N - 1));

        state_next    = state;
        a_sh_next     = a_sh;
        b_sh_next     = b_sh;
        res_next      = res;
        c_next_reg    = c;
        cnt_next      = cnt;
        busy_next     = busy;
        done_next     = 1'b0;
        sum_next      = sum;
        carry_next    = carry;
        overflow_next = overflow;
        zero_next     = zero;

        case (state)
            IDLE: begin
                if (start) begin
                    a_sh_next  = a;
                    b_sh_next  = mode ? ~b : b;
                    c_next_reg = mode;
                    res_next   = '0;
                    cnt_next   = '0;
                    busy_next  = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                a_sh_next  = a_sh >> DIGIT;
                b_sh_next  = b_sh >> DIGIT;
                res_next   = res_shift;
                c_next_reg = c_next;
                cnt_next   = cnt + CW'(1);
                if (last) begin
                    sum_next      = res_shift;
                    carry_next    = c_next;
                    overflow_next = c_msb_in ^ c_next;
                    zero_next     = (res_shift == '0);
                    done_next     = 1'b1;
                    busy_next     = 1'b0;
                    cnt_next      = '0;
                    state_next    = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: the shift registers are datapath state too, so they are cleared with the
        // flags; a reset mid-operation then leaves nothing stale behind.
        if (!rst_n) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            res      <= '0;
            c        <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state    <= state_next;
            a_sh     <= a_sh_next;
            b_sh     <= b_sh_next;
            res      <= res_next;
            c        <= c_next_reg;
            cnt      <= cnt_next;
            busy     <= busy_next;
            done     <= done_next;
            sum      <= sum_next;
            carry    <= carry_next;
            overflow <= overflow_next;
            zero     <= zero_next;
        end
    end

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub: four instances (8/2, 8/8, 8/1, 16/4) checked
// against an arithmetic reference model with directed and random vectors.
module tb_serial_add_sub;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode;
    logic [15:0] a, b;
    logic        start_i [4];
    logic        busy_o  [4];
    logic        done_o  [4];
    logic        carry_o [4];
    logic        ovf_o   [4];
    logic        zero_o  [4];
    logic [15:0] sum_o   [4];
    logic [7:0]  sum_w0, sum_w1, sum_w2;
    logic [15:0] sum_w3;

    int w_of [4] = '{8, 8, 8, 16};
    int n_of [4] = '{4, 1, 8, 4};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_add_sub #(.WIDTH(8), .DIGIT(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_i[0]), .mode(mode), .a(a[7:0]), .b(b[7:0]),
        .busy(busy_o[0]), .done(done_o[0]), .sum(sum_w0), .carry(carry_o[0]),
        .overflow(ovf_o[0]), .zero(zero_o[0]));
    serial_add_sub #(.WIDTH(8), .DIGIT(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_i[1]), .mode(mode), .a(a[7:0]), .b(b[7:0]),
        .busy(busy_o[1]), .done(done_o[1]), .sum(sum_w1), .carry(carry_o[1]),
        .overflow(ovf_o[1]), .zero(zero_o[1]));
    serial_add_sub #(.WIDTH(8), .DIGIT(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_i[2]), .mode(mode), .a(a[7:0]), .b(b[7:0]),
        .busy(busy_o[2]), .done(done_o[2]), .sum(sum_w2), .carry(carry_o[2]),
        .overflow(ovf_o[2]), .zero(zero_o[2]));
    serial_add_sub #(.WIDTH(16), .DIGIT(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start_i[3]), .mode(mode), .a(a), .b(b),
        .busy(busy_o[3]), .done(done_o[3]), .sum(sum_w3), .carry(carry_o[3]),
        .overflow(ovf_o[3]), .zero(zero_o[3]));

    assign sum_o[0] = {8'h00, sum_w0};
    assign sum_o[1] = {8'h00, sum_w1};
    assign sum_o[2] = {8'h00, sum_w2};
    assign sum_o[3] = sum_w3;

    // Reference: plain integer arithmetic on the w-bit operands.
    function automatic void model(input int w, input logic m, input logic [15:0] x,
                                  input logic [15:0] y, output logic [15:0] s,
                                  output logic c, output logic o, output logic z);
        longint mask, half, ux, uy, r, sx, sy, sr;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ux = longint'(x) & mask;
        uy = longint'(y) & mask;
        r  = m ? (ux - uy) : (ux + uy);
        s  = 16'(r & mask);
        c  = m ? (ux >= uy) : (r > mask);
        sx = (ux >= half) ? ux - (mask + 1) : ux;
        sy = (uy >= half) ? uy - (mask + 1) : uy;
        sr = m ? (sx - sy) : (sx + sy);
        o  = (sr > half - 1) || (sr < -half);
        z  = ((r & mask) == 0);
    endfunction

    task automatic cmp(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Present operands away from the edge, let the next edge sample them, then scramble.
    task automatic launch(input int k, input logic m, input logic [15:0] x, input logic [15:0] y);
        start_i[k] = 1'b1;
        mode = m;
        a = x;
        b = y;
        @(posedge clk);
        #1;
        start_i[k] = 1'b0;
        mode = 1'($urandom);
        a = 16'($urandom);
        b = 16'($urandom);
    endtask

    // Called #1 after the sampling edge; returns #1 after the edge that raised done.
    task automatic finish_check(input int k, input logic m, input logic [15:0] x,
                                input logic [15:0] y, input bit poke, input string name);
        int edges = 1;
        int busyc = 0;
        logic [15:0] held = sum_o[k];
        logic [15:0] es;
        logic ec, eo, ez;
        model(w_of[k], m, x, y, es, ec, eo, ez);
        while (done_o[k] !== 1'b1 && edges < 40) begin
            if (busy_o[k] === 1'b1) busyc++;
            cmp({name, " sum_hold"}, sum_o[k], held);
            if (poke && edges == 2) begin
                start_i[k] = 1'b1;
                a = 16'h0011;
                b = 16'h0011;
            end else begin
                start_i[k] = 1'b0;
            end
            @(posedge clk);
            #1;
            edges++;
        end
        start_i[k] = 1'b0;
        cmp({name, " done_latency"}, edges, n_of[k] + 1);
        cmp({name, " busy_cycles"}, busyc, n_of[k]);
        cmp({name, " busy_at_done"}, busy_o[k], 0);
        cmp({name, " sum"}, sum_o[k], es);
        cmp({name, " carry"}, carry_o[k], ec);
        cmp({name, " overflow"}, ovf_o[k], eo);
        cmp({name, " zero"}, zero_o[k], ez);
    endtask

    task automatic run_vec(input int k, input logic m, input logic [15:0] x,
                           input logic [15:0] y, input string name);
        @(negedge clk);
        launch(k, m, x, y);
        finish_check(k, m, x, y, 1'b0, name);
        @(posedge clk);
        #1;
        cmp({name, " done_pulse_width"}, done_o[k], 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            cmp($sformatf("reset%0d busy", k), busy_o[k], 0);
            cmp($sformatf("reset%0d done", k), done_o[k], 0);
            cmp($sformatf("reset%0d sum", k), sum_o[k], 0);
            cmp($sformatf("reset%0d flags", k), {carry_o[k], ovf_o[k], zero_o[k]}, 0);
        end
        rst_n = 1'b1;
    endtask

    logic        vm [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] va [7] = '{16'h05, 16'h08, 16'h02, 16'h7F, 16'hFF, 16'h80, 16'h00};
    logic [15:0] vb [7] = '{16'h03, 16'h02, 16'h08, 16'h01, 16'h01, 16'h01, 16'h00};

    task automatic test_add_sub();
        for (int i = 0; i < 7; i++)
            run_vec(0, vm[i], va[i], vb[i], $sformatf("vec%0d", i));
    endtask

    task automatic test_sweep();
        for (int k = 1; k < 3; k++)
            for (int i = 0; i < 7; i++)
                run_vec(k, vm[i], va[i], vb[i], $sformatf("sweep%0d_vec%0d", k, i));
        run_vec(3, 1'b1, 16'h8000, 16'h0001, "w16_sub_ovf");
        cmp("w16 literal sum", sum_o[3], 16'h7FFF);
        cmp("w16 literal ovf", ovf_o[3], 1);
    endtask

    task automatic test_busy_ignore();
        @(negedge clk);
        launch(0, 1'b0, 16'h05, 16'h03);
        finish_check(0, 1'b0, 16'h05, 16'h03, 1'b1, "busy_ignore");
        cmp("busy_ignore literal", sum_o[0], 16'h08);
        @(posedge clk);
        #1;
        cmp("busy_ignore single_done", done_o[0], 0);
        cmp("busy_ignore idle", busy_o[0], 0);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        launch(0, 1'b0, 16'h05, 16'h03);
        finish_check(0, 1'b0, 16'h05, 16'h03, 1'b0, "b2b_first");
        launch(0, 1'b1, 16'h10, 16'h30);
        finish_check(0, 1'b1, 16'h10, 16'h30, 1'b0, "b2b_second");
        @(posedge clk);
        #1;
        cmp("b2b done_pulse_width", done_o[0], 0);
    endtask

    task automatic test_reset_mid_op();
        bit saw_done = 1'b0;
        run_vec(0, 1'b0, 16'h7F, 16'h01, "pre_reset");
        @(negedge clk);
        launch(0, 1'b0, 16'h05, 16'h03);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cmp("midreset busy", busy_o[0], 0);
        cmp("midreset done", done_o[0], 0);
        cmp("midreset sum", sum_o[0], 0);
        cmp("midreset flags", {carry_o[0], ovf_o[0], zero_o[0]}, 0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done_o[0] === 1'b1) saw_done = 1'b1;
        end
        cmp("midreset no_done", saw_done, 0);
        run_vec(0, 1'b1, 16'h02, 16'h08, "post_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int k = int'($urandom_range(0, 3));
            run_vec(k, 1'($urandom), 16'($urandom), 16'($urandom), $sformatf("rand%0d_k%0d", i, k));
        end
    endtask

    initial begin
        rst_n = 1'b1;
        mode  = 1'b0;
        a     = '0;
        b     = '0;
        for (int k = 0; k < 4; k++) start_i[k] = 1'b0;
        test_reset();
        test_add_sub();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_op();
        test_sweep();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_add_sub.md
Name: serial_add_sub

Overview:
- Parametrised, multi-cycle adder/subtractor. Processes operands LSB-first, DIGIT bits per clock, using a start/busy/done handshake.
- Produces sum, carry, signed overflow and zero flags.
- Generalises the combinational 4-bit add/sub in width and digit size, trading area for latency. Used in datapaths that can tolerate WIDTH/DIGIT cycles of latency.

Parameters:
- WIDTH, 8, operand and result width in bits (>=2).
- DIGIT, 2, bits processed per cycle. WIDTH must be an integer multiple of DIGIT; otherwise elaboration fails.
- N (localparam), WIDTH/DIGIT, number of processing cycles.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, synchronous, active-low
- start  input  1  request a new operation; sampled only when the unit is not busy
- mode  input  1  0 = ADD (a+b), 1 = SUB (a-b); sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when the result is valid
- sum  output  WIDTH  result, modulo 2^WIDTH
- carry  output  1  carry out of the MSB. ADD: unsigned overflow. SUB: 1 means no borrow (a>=b unsigned).
- overflow  output  1  two's-complement signed overflow
- zero  output  1  sum == 0

Behaviour:
- Single clock domain. Reset is synchronous and active-low: rst_n sampled low at a rising edge forces the reset state.
- Reset values: state IDLE; busy=0, done=0, sum=0, carry=0, overflow=0, zero=0; internal shift registers and digit counter cleared.
- FSM states: IDLE, RUN.
- IDLE, start=1 at edge E0:
  - latch a into A_sh.
  - latch (mode ? ~b : b) into B_sh.
  - set carry register c = mode.
  - clear the result shift register and cnt.
  - enter RUN; busy=1 from E0.
  - start=0 in IDLE: no state change; outputs hold.
- RUN, each edge E1..EN processes digit cnt:
  - {c_next, d} = A_sh[DIGIT-1:0] + B_sh[DIGIT-1:0] + c.
  - shift d into the result register from the MSB end; shift A_sh and B_sh right by DIGIT.
  - c <= c_next; cnt increments.
  - Also capture the carry into the MSB (c_msb_in) on the final digit, needed for overflow.
- At edge EN (last digit, cnt==N-1):
  - sum <= the full result.
  - carry <= final c_next.
  - overflow <= c_msb_in XOR c_next, where c_msb_in is the carry into bit WIDTH-1.
  - zero <= (result == 0).
  - done <= 1, busy <= 0; state returns to IDLE.
- Latency: the result is visible and done=1 in the cycle after EN, i.e. N+1 edges after start is sampled. done is high for exactly one cycle; the next edge clears it unless another completion occurs.
- sum/carry/overflow/zero hold their last completed values until the next completion. They never change while busy=1.
- start while busy=1: ignored. Operands are not re-sampled and the operation in flight is unaffected.
- Back-to-back: start=1 during the done cycle (state IDLE) is accepted; the next done arrives N+1 edges later. Throughput is 1 op per N+1 cycles.
- Reset mid-operation: the operation is aborted, all outputs go to their reset values, and no done pulse is emitted.
- mode, a and b may change freely after the sampling edge.
- No combinational path from any input to any output; all outputs are registered.

Test Plan (WIDTH=8, DIGIT=2 unless stated; N=4):
- ADD a=0x05 b=0x03 -> done exactly 5 edges after the start edge; sum=0x08 carry=0 overflow=0 zero=0; busy high for 4 cycles.
- SUB a=0x08 b=0x02 -> sum=0x06 carry=1 overflow=0. SUB a=0x02 b=0x08 -> sum=0xFA carry=0 overflow=0.
- ADD a=0x7F b=0x01 -> sum=0x80 overflow=1 carry=0. ADD a=0xFF b=0x01 -> sum=0x00 carry=1 zero=1. SUB a=0x80 b=0x01 -> sum=0x7F overflow=1 carry=1.
- Start pulse with a=0x11 while busy on a 0x05+0x03 op -> ignored; result is still 0x08 and there is exactly one done pulse. Start asserted in the done cycle -> second result 5 edges later.
- rst_n low for one edge at RUN cnt=2 -> busy=0, done never pulses, all outputs 0. A new start afterwards completes normally.
- Parameter sweep with DIGIT=8 (N=1, done 2 edges after start) and DIGIT=1 (N=8), running the same vectors -> identical results. WIDTH=16, DIGIT=4: 0x8000-0x0001 -> 0x7FFF overflow=1.
